// File: rtl/mem_wb_stage_pkg.sv
// ----------------------------------------------------------------------------
// mem_wb_stage_pkg : memory-op / access-size encodings and FSM states
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_wb_stage_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_LOAD  = 2'b01,
    MEM_STORE = 2'b10
  } mem_op_t;

  // Encodings follow RISC-V funct3 for loads/stores.
  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_LOAD_REQ  = 2'b01,
    ST_LOAD_DATA = 2'b10
  } state_t;

  // Unused size codes fall into the default and are reported as misaligned.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] off);
    logic mis;
    mis = 1'b1;
    case (size)
      SZ_B, SZ_BU: mis = 1'b0;
      SZ_H, SZ_HU: mis = off[0];
      SZ_W:        mis = (off != 2'b00);
      default:     mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_wb_stage_lsu_load_align.sv
// ----------------------------------------------------------------------------
// lsu_load_align : selects the addressed lane of a load word and extends it
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lsu_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      size_i,
  output logic [XLEN-1:0] value_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = data_i >> {offset_i, 3'b000};

  always_comb begin
    value_o = '0;
    case (size_i)
      SZ_B:    value_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      SZ_H:    value_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      SZ_W:    value_o = shifted;
      SZ_BU:   value_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
      SZ_HU:   value_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      default: value_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ----------------------------------------------------------------------------
// mem_wb_stage : register writeback, byte/half/word stores and loads to RAM
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   alu_result,
  input  logic [1:0]        mem_op,
  input  logic [2:0]        mem_size,
  input  logic [XLEN-1:0]   store_data,
  input  logic [REG_AW-1:0] dst_addr,
  input  logic              dst_en,
  output logic              rd_ram_en,
  output logic [XLEN-1:0]   rd_ram_addr,
  input  logic [XLEN-1:0]   rd_ram_data,
  output logic              wr_ram_en,
  output logic [XLEN-1:0]   wr_ram_addr,
  output logic [XLEN-1:0]   wr_ram_data,
  output logic [3:0]        wr_ram_be,
  output logic              reg_wr_en,
  output logic [REG_AW-1:0] reg_wr_addr,
  output logic [XLEN-1:0]   reg_wr_data,
  output logic              misalign_err
);

  state_t              state_q, state_d;
  logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d, rg_en_q, rg_en_d, mis_q, mis_d;
  logic [XLEN-1:0]     rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
  logic [3:0]          wr_be_q, wr_be_d;
  logic [REG_AW-1:0]   rg_addr_q, rg_addr_d, ld_dst_q, ld_dst_d;
  logic [XLEN-1:0]     rg_data_q, rg_data_d;
  logic [2:0]          ld_size_q, ld_size_d;
  logic [1:0]          ld_off_q, ld_off_d;
  logic                ld_wb_q, ld_wb_d;

  logic                accept, wb_ok, size_mis;
  logic [1:0]          off;
  logic [XLEN-1:0]     word_addr, load_value;

  assign in_ready  = (state_q == ST_IDLE);
  assign accept    = in_valid && in_ready;
  assign off       = alu_result[1:0];
  assign word_addr = {alu_result[XLEN-1:2], 2'b00};
  assign wb_ok     = dst_en && (dst_addr != '0);
  assign size_mis  = is_misaligned(mem_size, off);

  lsu_load_align #(.XLEN(XLEN)) u_align (
    .data_i   (rd_ram_data),
    .offset_i (ld_off_q),
    .size_i   (ld_size_q),
    .value_o  (load_value)
  );

  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    rg_en_d   = 1'b0;
    mis_d     = 1'b0;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_be_d   = wr_be_q;
    rg_addr_d = rg_addr_q;
    rg_data_d = rg_data_q;
    ld_dst_d  = ld_dst_q;
    ld_size_d = ld_size_q;
    ld_off_d  = ld_off_q;
    ld_wb_d   = ld_wb_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (mem_op)
            MEM_NONE: begin
              rg_en_d = wb_ok;
              if (wb_ok) begin
                rg_addr_d = dst_addr;
                rg_data_d = alu_result;
              end
            end
            MEM_LOAD: begin
              if (size_mis) begin
                mis_d = 1'b1;
              end else begin
                rd_en_d   = 1'b1;
                rd_addr_d = word_addr;
                ld_size_d = mem_size;
                ld_off_d  = off;
                ld_dst_d  = dst_addr;
                ld_wb_d   = wb_ok;
                state_d   = ST_LOAD_REQ;
              end
            end
            MEM_STORE: begin
              // Stores only know B/H/W; the unsigned size codes are rejected too.
              if (size_mis || mem_size[2]) begin
                mis_d = 1'b1;
              end else begin
                wr_en_d   = 1'b1;
                wr_addr_d = word_addr;
                case (mem_size)
                  SZ_B: begin
                    wr_data_d = {4{store_data[7:0]}};
                    wr_be_d   = 4'b0001 << off;
                  end
                  SZ_H: begin
                    wr_data_d = {2{store_data[15:0]}};
                    wr_be_d   = 4'b0011 << {off[1], 1'b0};
                  end
                  default: begin
                    wr_data_d = store_data;
                    wr_be_d   = 4'b1111;
                  end
                endcase
              end
            end
            default: ;
          endcase
        end
      end
      ST_LOAD_REQ: state_d = ST_LOAD_DATA;
      ST_LOAD_DATA: begin
        // RAM data is valid during this cycle; write it back next cycle.
        state_d = ST_IDLE;
        rg_en_d = ld_wb_q;
        if (ld_wb_q) begin
          rg_addr_d = ld_dst_q;
          rg_data_d = load_value;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rg_en_q   <= 1'b0;
      mis_q     <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_be_q   <= '0;
      rg_addr_q <= '0;
      rg_data_q <= '0;
      ld_dst_q  <= '0;
      ld_size_q <= '0;
      ld_off_q  <= '0;
      ld_wb_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      rg_en_q   <= rg_en_d;
      mis_q     <= mis_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_be_q   <= wr_be_d;
      rg_addr_q <= rg_addr_d;
      rg_data_q <= rg_data_d;
      ld_dst_q  <= ld_dst_d;
      ld_size_q <= ld_size_d;
      ld_off_q  <= ld_off_d;
      ld_wb_q   <= ld_wb_d;
    end
  end

  assign rd_ram_en    = rd_en_q;
  assign rd_ram_addr  = rd_addr_q;
  assign wr_ram_en    = wr_en_q;
  assign wr_ram_addr  = wr_addr_q;
  assign wr_ram_data  = wr_data_q;
  assign wr_ram_be    = wr_be_q;
  assign reg_wr_en    = rg_en_q;
  assign reg_wr_addr  = rg_addr_q;
  assign reg_wr_data  = rg_data_q;
  assign misalign_err = mis_q;

endmodule

`default_nettype wire
